// File: rtl/fp32_addsub_seq.sv
// Multi-cycle handshaked IEEE-754 single-precision add/subtract engine.
// Denormals flush to zero, any exp-255 operand yields the canonical quiet NaN, and rounding is to nearest-even.
module fp32_addsub_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] z
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADDSUB, NORM, ROUND, RESP} state_t;

  state_t      state;
  logic        op_r;
  logic [31:0] a_r, b_r;
  logic [26:0] sig_l, sig_s;
  logic [27:0] sum;
  logic [9:0]  exp_r;
  logic        sign_r, eff_sub_r, nan_r, zero_r;

  logic [7:0]  ea, eb, e_big, e_small, d;
  logic [23:0] ma, mb, m_big, m_small;
  logic        sa, sb, a_ge_b, sticky;
  logic [26:0] small_ext, small_sh;

  assign req_ready = (state == IDLE);

  // Alignment of the registered operands: magnitude compare, swap and sticky shift.
  always_comb begin
    ea      = a_r[30:23];
    eb      = b_r[30:23];
    ma      = (ea != '0) ? {1'b1, a_r[22:0]} : '0;
    mb      = (eb != '0) ? {1'b1, b_r[22:0]} : '0;
    sa      = a_r[31];
    sb      = b_r[31] ^ op_r;
    a_ge_b  = ({ea, ma} >= {eb, mb});
    e_big   = a_ge_b ? ea : eb;
    e_small = a_ge_b ? eb : ea;
    m_big   = a_ge_b ? ma : mb;
    m_small = a_ge_b ? mb : ma;
    d       = e_big - e_small;
    small_ext = {m_small, 3'b000};
    small_sh  = '0;
    sticky    = |m_small;
    if (d < 8'd27) begin
      small_sh = small_ext >> d;
      sticky   = |(small_ext & ~({27{1'b1}} << d));
    end
  end

  logic        rnd_up;
  logic [24:0] mant_rnd;
  logic [9:0]  exp_rnd;
  logic [22:0] frac_rnd;

  always_comb begin
    rnd_up   = sum[2] & (sum[1] | sum[0] | sum[3]);
    mant_rnd = {1'b0, sum[26:3]} + {24'd0, rnd_up};
    exp_rnd  = exp_r + {9'd0, mant_rnd[24]};
    frac_rnd = mant_rnd[24] ? mant_rnd[23:1] : mant_rnd[22:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_r      <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      sig_l     <= '0;
      sig_s     <= '0;
      sum       <= '0;
      exp_r     <= '0;
      sign_r    <= 1'b0;
      eff_sub_r <= 1'b0;
      nan_r     <= 1'b0;
      zero_r    <= 1'b0;
      rsp_valid <= 1'b0;
      z         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_r  <= op;
            a_r   <= a;
            b_r   <= b;
            state <= ALIGN;
          end
        end
        ALIGN: begin
          sig_l     <= {m_big, 3'b000};
          sig_s     <= {small_sh[26:1], small_sh[0] | sticky};
          exp_r     <= {2'b00, e_big};
          sign_r    <= a_ge_b ? sa : sb;
          eff_sub_r <= sa ^ sb;
          nan_r     <= (ea == 8'hFF) | (eb == 8'hFF);
          state     <= ADDSUB;
        end
        ADDSUB: begin
          sum    <= eff_sub_r ? ({1'b0, sig_l} - {1'b0, sig_s}) : ({1'b0, sig_l} + {1'b0, sig_s});
          zero_r <= 1'b0;
          state  <= NORM;
        end
        NORM: begin
          if (sum[27]) begin
            sum   <= {1'b0, sum[27:2], sum[1] | sum[0]};
            exp_r <= exp_r + 10'd1;
            state <= ROUND;
          end else if (sum == '0) begin
            zero_r <= 1'b1;
            if (eff_sub_r) sign_r <= 1'b0;
            state  <= ROUND;
          end else if (sum[26]) begin
            state <= ROUND;
          end else begin
            // One left shift per cycle; hitting exponent 0 flushes the result.
            sum   <= {sum[26:0], 1'b0};
            exp_r <= exp_r - 10'd1;
            if (exp_r == 10'd1) begin
              zero_r <= 1'b1;
              state  <= ROUND;
            end else if (sum[25]) begin
              state <= ROUND;
            end
          end
        end
        ROUND: begin
          if (nan_r)                 z <= 32'h7FC0_0000;
          else if (zero_r)           z <= {sign_r, 31'd0};
          else if (exp_rnd >= 10'd255) z <= {sign_r, 8'hFF, 23'd0};
          else                       z <= {sign_r, exp_rnd[7:0], frac_rnd};
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_addsub_seq.sv
// Self-checking bench for fp32_addsub_seq: directed cases, backpressure, reset abort,
// and randomized operands compared against an exact-integer rounding model.
module tb_fp32_addsub_seq;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        op;
  logic [31:0] a, b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] z;

  int n_checks = 0;
  int n_errors = 0;

  fp32_addsub_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .z         (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp_v);
    end
  endtask

  // Exact integer sum/difference, then round-to-nearest-even on the true value.
  function automatic logic [31:0] ref_addsub(input logic op_i, input logic [31:0] x, input logic [31:0] y);
    int unsigned ex, ey, el, es, d;
    longint unsigned mx, my, ml, ms, vl, vs, r, keep, rem, half;
    logic sx, sy, sl, sub;
    int scale, p, e, k;
    ex = x[30:23];
    ey = y[30:23];
    if (ex == 255 || ey == 255) return 32'h7FC0_0000;
    mx = (ex != 0) ? (64'h80_0000 | 64'(x[22:0])) : 64'd0;
    my = (ey != 0) ? (64'h80_0000 | 64'(y[22:0])) : 64'd0;
    sx = x[31];
    sy = y[31] ^ op_i;
    sub = sx ^ sy;
    if ((ex > ey) || (ex == ey && mx >= my)) begin
      el = ex; ml = mx; sl = sx; es = ey; ms = my;
    end else begin
      el = ey; ml = my; sl = sy; es = ex; ms = mx;
    end
    if (ml == 0) return sub ? 32'd0 : {sl, 31'd0};
    d = el - es;
    if (d > 30) begin
      vl = ml << 30; vs = (ms != 0) ? 64'd1 : 64'd0; scale = int'(el) - 30;
    end else begin
      vl = ml << d;  vs = ms;                         scale = int'(es);
    end
    r = sub ? (vl - vs) : (vl + vs);
    if (r == 0) return 32'd0;
    p = 63;
    while (!r[p]) p--;
    e = scale + p - 23;
    if (e <= 0) return {sl, 31'd0};
    if (p > 23) begin
      k    = p - 23;
      keep = r >> k;
      rem  = r & ((64'd1 << k) - 1);
      half = 64'd1 << (k - 1);
      if (rem > half || (rem == half && keep[0])) keep++;
    end else begin
      keep = r << (23 - p);
    end
    if (keep == 64'h100_0000) begin
      keep = keep >> 1;
      e++;
    end
    if (e >= 255) return {sl, 8'hFF, 23'd0};
    return {sl, e[7:0], keep[22:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input string tag, output int cnt);
    cnt = 0;
    while (!rsp_valid && cnt < 40) begin
      step();
      cnt++;
    end
    if (!rsp_valid) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic issue(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i);
    op = op_i; a = a_i; b = b_i; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    op = 1'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic run_txn(input string tag, input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                         input logic [31:0] exp_z, input int exp_lat);
    int cnt;
    issue(op_i, a_i, b_i);
    wait_rsp(tag, cnt);
    check({tag, "_z"}, z, exp_z);
    if (exp_lat > 0) check({tag, "_lat"}, cnt, exp_lat);
    step();
  endtask

  initial begin
    int cnt;
    logic [31:0] z_hold, ra, rb;
    logic rop;
    bit seen;
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1; op = 1'b0; a = '0; b = '0;
    step(); step();
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_z", z, 32'd0);
    rst_n = 1'b1;
    step();

    run_txn("one_plus_one", 1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 4);
    run_txn("one_minus_3q", 1'b1, 32'h3F80_0000, 32'h3F40_0000, 32'h3E80_0000, 5);
    run_txn("three_plus_m2", 1'b0, 32'h4040_0000, 32'hC000_0000, 32'h3F80_0000, 0);
    run_txn("x_minus_x", 1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 4);
    run_txn("tie_even", 1'b0, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 0);
    run_txn("tie_odd", 1'b0, 32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002, 0);
    run_txn("overflow", 1'b0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 0);
    run_txn("inf_nan", 1'b0, 32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 0);
    run_txn("denorm_flush", 1'b0, 32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, 0);
    run_txn("neg0_plus_neg0", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 0);
    run_txn("neg0_minus_pos0", 1'b1, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 0);

    // Backpressure, with a second request waiting behind the stalled response.
    rsp_ready = 1'b0;
    issue(1'b0, 32'h3F80_0000, 32'h3F80_0000);
    wait_rsp("bp", cnt);
    z_hold = z;
    check("bp_z", z, 32'h4000_0000);
    op = 1'b0; a = 32'h4040_0000; b = 32'hC000_0000; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_hold_z", z, z_hold);
      check("bp_hold_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    check("bp_release_ready", {31'd0, req_ready}, 32'd1);
    check("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    req_valid = 1'b0;
    check("bp_next_accepted", {31'd0, req_ready}, 32'd0);
    wait_rsp("bp_next", cnt);
    check("bp_next_z", z, 32'h3F80_0000);
    step();

    // Reset while the 1.0-0.75 request sits in NORM.
    issue(1'b1, 32'h3F80_0000, 32'h3F40_0000);
    step(); step();
    rst_n = 1'b0;
    #1;
    check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort_z", z, 32'd0);
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rsp_valid) seen = 1'b1;
    end
    check("abort_no_rsp", {31'd0, seen}, 32'd0);
    run_txn("after_abort", 1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 4);

    for (int t = 0; t < 300; t++) begin
      ra = $urandom; rb = $urandom; rop = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: begin
          rb[30:23] = ra[30:23] - 8'($urandom_range(0, 1));
          rb[22:8]  = ra[22:8];
        end
        1: begin
          ra[30:23] = 8'($urandom_range(1, 3));
          rb[30:23] = ra[30:23];
          rb[22:12] = ra[22:12];
        end
        2: ra[30:23] = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF;
        3: begin
          ra[30:23] = 8'hFE;
          rb[30:23] = 8'($urandom_range(250, 254));
        end
        4: rb[30:23] = ra[30:23] - 8'($urandom_range(20, 32));
        default: ;
      endcase
      run_txn("rand", rop, ra, rb, ref_addsub(rop, ra, rb), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fp32_addsub_seq.md
# fp32_addsub_seq

Multi-cycle, handshaked IEEE-754 single-precision add/subtract engine. It is the serving end of the add/sub operation that the FFT butterfly datapath issues: it accepts one signed operand pair plus an op bit per request and returns the rounded result on a response channel. It replaces combinational sum/difference cores where area matters more than throughput.

## Interface
- No parameters; the format is fixed to FP32 (sign 31, exponent 30:23, mantissa 22:0).
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: engine idle and able to accept a request; `req_ready = (state==IDLE)`.
- `op` in 1: 0 = add (a+b), 1 = subtract (a-b).
- `a`, `b` in 32: operands, captured on accept.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer takes the result.
- `z` out 32: result.

## Operation
- FSM states: IDLE, ALIGN, ADDSUB, NORM, ROUND, RESP.
- IDLE: a request is accepted on a `req_valid && req_ready` edge. On that edge, register `op`, `a` and `b`, then go to ALIGN.
- Specials:
  - An operand with exponent 0 is treated as signed zero (denormals are flushed).
  - An operand with exponent 255 forces `z = 0x7FC00000`. The request still takes the normal FSM path.
- Effective operation: `eff_sub = op ^ a[31] ^ b[31]`. Result sign is the sign of the larger-magnitude operand, with the sign of b inverted when `op` = 1.
- ALIGN:
  - Form 24-bit significands with the hidden bit set, then append 3 guard/round/sticky bits (27 bits).
  - Swap so that |A| ≥ |B|, comparing exponent first and then mantissa.
  - Shift B right by d = eA − eB in one cycle. Shifted-out bits OR into sticky.
  - If d ≥ 27, B becomes sticky only (sticky = 1 if B is nonzero).
- ADDSUB: 28-bit sum or difference of the two significands.
- NORM:
  - If bit 27 is set: shift right by 1 with sticky, exponent + 1, one cycle.
  - Else if the result is zero: one cycle, then the result is +0. The exception is (−0)+(−0) or the equivalent under subtract, which gives −0.
  - Else shift left by 1 per cycle, exponent − 1 per cycle, until bit 26 is set.
  - If the exponent reaches 0 during this, stop; the result is signed zero (underflow).
  - Cycles spent in NORM: n = max(1, number of left shifts).
- ROUND:
  - Round to nearest, ties to even, using guard, round|sticky and the LSB.
  - A carry out of the mantissa renormalises: exponent + 1.
  - Exponent ≥ 255 gives signed infinity (`0x7F800000` or `0xFF800000`).
- RESP:
  - `rsp_valid` = 1 and `z` is held stable until a `rsp_valid && rsp_ready` edge, then the FSM returns to IDLE.
  - No new request is accepted in the same cycle as the response handshake.

## Timing
- Reset values: state = IDLE, `req_ready` = 1, `rsp_valid` = 0, `z` = 0x00000000.
- Asserting reset mid-operation aborts the operation. No response is produced, and the engine is in IDLE after reset is released.
- Latency: `rsp_valid` rises 3+n cycles after the accept edge. The minimum is 4 cycles; the maximum is 27 cycles.
- One request is in flight at a time. `req_ready` is low from the accept edge until the cycle after the response handshake.
- `rsp_valid` must not drop, and `z` must not change, while `rsp_ready` = 0.
- Changes on `a`, `b` and `op` after the accept edge have no effect on the result.

## Test plan
- 1.0 + 1.0: `op`=0, `a`=0x3F800000, `b`=0x3F800000 -> `z`=0x40000000. n=1 (carry shift), so `rsp_valid` rises 4 cycles after accept.
- Cancellation and signs:
  - `op`=1, `a`=0x3F800000, `b`=0x3F400000 (1.0 − 0.75) -> `z`=0x3E800000, 2 left shifts, latency 5.
  - `op`=0, `a`=0x40400000, `b`=0xC0000000 (3.0 + −2.0) -> `z`=0x3F800000.
  - `op`=1, `a`=`b`=0x3F800000 -> `z`=0x00000000.
- Rounding ties:
  - `a`=0x3F800000 + `b`=0x33800000 -> `z`=0x3F800000 (tie, LSB even, round down).
  - `a`=0x3F800001 + `b`=0x33800000 -> `z`=0x3F800002 (tie, LSB odd, round up).
- Specials:
  - 0x7F7FFFFF + 0x7F7FFFFF -> `z`=0x7F800000 (overflow).
  - `a`=0x7F800000 with any `b` -> `z`=0x7FC00000.
  - `a`=0x00000001 (denormal) + 0x3F800000 -> `z`=0x3F800000 (denormal flushed).
- Backpressure: hold `rsp_ready`=0 for 3 cycles after `rsp_valid` rises. `z` and `rsp_valid` must stay stable and `req_ready` must stay 0. Release `rsp_ready`: `req_ready` must be 1 on the next cycle.
- Reset abort: assert `rst_n`=0 during NORM of a 1.0 − 0.75 request. `rsp_valid` and `z` must read 0 immediately, with no response after release. A following 1.0 + 1.0 request must complete normally.
